// File: rtl/cdb_scheduler.sv
// CDB write-back scheduler for the issue stage.
// Keeps a reservation table of upcoming CDB cycles and grants an issue only
// when the write-back slot at that unit's latency is free. Integer and
// load/store share latency 1; contention between them alternates.
//
// Table entry i describes the CDB in cycle t+i. A grant of latency L made in
// cycle t is written into entry L-1 at the next edge, so it reaches entry 0
// (and therefore the CDB) in cycle t+L.
module cdb_scheduler #(
   parameter int MULT_LAT = 3,
   parameter int DIV_LAT  = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       int_req,
   input  logic       ls_req,
   input  logic       mult_req,
   input  logic       div_req,
   input  logic       div_busy,
   output logic       int_grant,
   output logic       ls_grant,
   output logic       mult_grant,
   output logic       div_grant,
   output logic       cdb_valid,
   output logic [3:0] cdb_sel,
   output logic       ls_prio
);

   localparam logic [1:0] OWN_LS   = 2'd0;
   localparam logic [1:0] OWN_MULT = 2'd1;
   localparam logic [1:0] OWN_DIV  = 2'd2;
   localparam logic [1:0] OWN_INT  = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [1:0] owner;
   } slot_t;

   slot_t occ [DIV_LAT];

   logic  lat1_free;
   logic  contention;
   slot_t lat1_entry;

   // Grant decision from current requests and reservation state.
   // The divider's slot (index DIV_LAT) lies past the table and is never taken.
   always_comb begin
      lat1_free  = ~occ[1].valid;
      contention = int_req & ls_req & lat1_free;
      int_grant  = reset & int_req & lat1_free & ~(ls_req & ls_prio);
      ls_grant   = reset & ls_req & lat1_free & ~(int_req & ~ls_prio);
      mult_grant = reset & mult_req & ~occ[MULT_LAT].valid;
      div_grant  = reset & div_req & ~div_busy;
      lat1_entry.valid = int_grant | ls_grant;
      lat1_entry.owner = int_grant ? OWN_INT : OWN_LS;
   end

   // Advance the reservation table one cycle, merge new grants, toggle tie-break.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DIV_LAT; i++) begin
            occ[i] <= '0;
         end
         ls_prio <= 1'b0;
      end else begin
         for (int i = 0; i < DIV_LAT-1; i++) begin
            occ[i] <= occ[i+1];
            if (i == 0 && lat1_entry.valid) begin
               occ[i] <= lat1_entry;
            end
            if (i == MULT_LAT-1 && mult_grant) begin
               occ[i] <= '{valid: 1'b1, owner: OWN_MULT};
            end
         end
         occ[DIV_LAT-1] <= div_grant ? '{valid: 1'b1, owner: OWN_DIV} : '0;
         if (contention) begin
            ls_prio <= ~ls_prio;
         end
      end
   end

   // CDB source select: one-hot decode of the current-cycle slot owner.
   always_comb begin
      cdb_sel   = 4'b0000;
      cdb_valid = occ[0].valid;
      if (occ[0].valid) begin
         cdb_sel[occ[0].owner] = 1'b1;
      end
   end

   // A slot may only ever be claimed once; these catch double-claims.
   a_int_ls_excl: assert property (@(posedge clk) disable iff (!reset)
      !(int_grant && ls_grant));
   a_lat1_free: assert property (@(posedge clk) disable iff (!reset)
      !((int_grant || ls_grant) && occ[1].valid));
   a_mult_free: assert property (@(posedge clk) disable iff (!reset)
      !(mult_grant && occ[MULT_LAT].valid));
   a_sel_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(cdb_sel));

endmodule

// File: tb/tb_cdb_scheduler.sv
// Bench for cdb_scheduler. The reference model books CDB cycles by absolute
// cycle number in an associative array; a monitor compares the bus every cycle.
module tb_cdb_scheduler;

   localparam int MULT_LAT = 3;
   localparam int DIV_LAT  = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       int_req, ls_req, mult_req, div_req, div_busy;
   logic       int_grant, ls_grant, mult_grant, div_grant;
   logic       cdb_valid;
   logic [3:0] cdb_sel;
   logic       ls_prio;

   cdb_scheduler #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .int_req    (int_req),
      .ls_req     (ls_req),
      .mult_req   (mult_req),
      .div_req    (div_req),
      .div_busy   (div_busy),
      .int_grant  (int_grant),
      .ls_grant   (ls_grant),
      .mult_grant (mult_grant),
      .div_grant  (div_grant),
      .cdb_valid  (cdb_valid),
      .cdb_sel    (cdb_sel),
      .ls_prio    (ls_prio)
   );

   always #5 clk = ~clk;

   int         pass_cnt = 0;
   int         total_cnt = 0;
   int         cyc = 0;
   bit         running = 0;

   // scoreboard: absolute cycle -> expected one-hot CDB source
   logic [3:0] exp_sel [int];
   logic       m_prio;
   logic       eint, els, emu, edv;
   logic [3:0] mon_e;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, req);
   endtask

   // monitor: compare the bus against the booked slot for this cycle
   always @(negedge clk) begin
      if (running) begin
         mon_e = exp_sel.exists(cyc) ? exp_sel[cyc] : 4'b0000;
         if (!reset) mon_e = 4'b0000;
         chk("cdb_sel", cdb_sel, mon_e);
         chk("cdb_valid", {3'b000, cdb_valid}, {3'b000, (mon_e != 4'b0000)});
         if (exp_sel.exists(cyc)) exp_sel.delete(cyc);
      end
   end

   task automatic step(input logic ir, input logic lr, input logic mr,
                       input logic dr, input logic db, input logic rs);
      @(posedge clk);
      #1;
      cyc++;
      int_req = ir; ls_req = lr; mult_req = mr; div_req = dr; div_busy = db;
      reset = rs;
      running = 1;
      eint = 0; els = 0; emu = 0; edv = 0;
      if (!rs) begin
         exp_sel.delete();
         m_prio = 0;
      end else begin
         edv = dr & ~db;
         emu = mr & !exp_sel.exists(cyc + MULT_LAT);
         if (!exp_sel.exists(cyc + 1)) begin
            if (ir && lr) begin
               if (m_prio) els = 1; else eint = 1;
            end else begin
               eint = ir;
               els  = lr;
            end
         end
      end
      @(negedge clk);
      chk("int_grant",  {3'b000, int_grant},  {3'b000, eint});
      chk("ls_grant",   {3'b000, ls_grant},   {3'b000, els});
      chk("mult_grant", {3'b000, mult_grant}, {3'b000, emu});
      chk("div_grant",  {3'b000, div_grant},  {3'b000, edv});
      chk("ls_prio",    {3'b000, ls_prio},    {3'b000, m_prio});
      if (eint) exp_sel[cyc + 1]        = 4'b1000;
      if (els)  exp_sel[cyc + 1]        = 4'b0001;
      if (emu)  exp_sel[cyc + MULT_LAT] = 4'b0010;
      if (edv)  exp_sel[cyc + DIV_LAT]  = 4'b0100;
      if (rs && ir && lr && !exp_sel.exists(cyc + 1) == 0 && (eint || els) && ir && lr)
         m_prio = ~m_prio;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 1);
   endtask

   logic ir, lr, mr, dr, db, rs;

   initial begin
      reset = 0; int_req = 0; ls_req = 0; mult_req = 0; div_req = 0; div_busy = 0;
      m_prio = 0;

      // reset held with every request high
      for (int k = 0; k < 3; k++) step(1, 1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      idle(2);

      // int/ls contention alternates
      for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0, 1);
      idle(2);

      // multiplier slot blocks a later int
      step(0, 0, 1, 0, 0, 1);
      idle(1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      idle(3);

      // divider free, then busy
      step(0, 0, 0, 1, 0, 1);
      idle(7);
      step(0, 0, 0, 1, 1, 1);
      idle(7);

      // div, mult and int together
      step(1, 0, 1, 1, 0, 1);
      idle(7);

      // reset while a divide is in flight
      step(0, 0, 0, 1, 0, 1);
      idle(2);
      step(0, 0, 0, 0, 0, 0);
      idle(5);

      // random traffic; requesters hold until granted
      ir = 0; lr = 0; mr = 0; dr = 0;
      for (int k = 0; k < 2000; k++) begin
         db = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 199) != 0);
         step(ir, lr, mr, dr, db, rs);
         ir = (ir & ~eint & rs) | ($urandom_range(0, 2) == 0);
         lr = (lr & ~els  & rs) | ($urandom_range(0, 2) == 0);
         mr = (mr & ~emu  & rs) | ($urandom_range(0, 3) == 0);
         dr = (dr & ~edv  & rs) | ($urandom_range(0, 5) == 0);
      end
      idle(DIV_LAT + 2);

      total_cnt++;
      if (exp_sel.size() == 0) pass_cnt++;
      else $display("FAIL sb_drain: %0d booked results never appeared, expected 0", exp_sel.size());

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
